// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake and decoded-instruction output bundle.
// The decode stage takes the slave side; the fetch/execute environment takes the master side.
interface decode_stage_if;
  // Upstream (fetch) side
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_instr;
  logic [7:0] in_pc;
  logic       flush;

  // Downstream (execute) side
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_opcode;
  logic [1:0] out_rs;
  logic [1:0] out_rt;
  logic [1:0] out_rd;
  logic [1:0] out_imm;
  logic [5:0] out_jtarget;
  logic [7:0] out_pc;
  logic [7:0] out_pc_plus1;
  logic       out_reg_write;
  logic       out_mem_read;
  logic       out_mem_write;
  logic       out_jump;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_imm,
           out_jtarget, out_pc, out_pc_plus1,
           out_reg_write, out_mem_read, out_mem_write, out_jump
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_imm,
           out_jtarget, out_pc, out_pc_plus1,
           out_reg_write, out_mem_read, out_mem_write, out_jump
  );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: decodes fetched instructions at push time and buffers up to
// DEPTH decoded entries in order. The outputs come from a dedicated head
// register that is reloaded only when a new entry becomes the head, so they
// hold their last values while the buffer is empty.
module decode_stage #(
  parameter int DEPTH = 2  // 2 or 4
) (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LWD = 2'b01;
  localparam logic [1:0] OP_SWD = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  typedef struct packed {
    logic [1:0] opcode;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] rd;        // also the raw immediate
    logic [5:0] jtarget;
    logic [7:0] pc;
    logic [7:0] pc_plus1;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       jump;
  } entry_t;

  function automatic entry_t decode(input logic [7:0] instr, input logic [7:0] pc);
    entry_t e;
    e          = '0;
    e.opcode   = instr[7:6];
    e.rs       = instr[5:4];
    e.rt       = instr[3:2];
    e.rd       = instr[1:0];
    e.jtarget  = instr[5:0];
    e.pc       = pc;
    e.pc_plus1 = pc + 8'd1;  // wraps 8'hFF -> 8'h00
    case (instr[7:6])
      OP_ADD:  e.reg_write = 1'b1;
      OP_LWD:  begin e.reg_write = 1'b1; e.mem_read = 1'b1; end
      OP_SWD:  e.mem_write = 1'b1;
      OP_JMP:  e.jump = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  entry_t           mem [DEPTH];
  entry_t           head;
  entry_t           head_nxt;
  entry_t           new_entry;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [CNT_W-1:0] count, cnt_nxt;
  logic             push, pop, load_head;

  assign new_entry     = decode(bus.in_instr, bus.in_pc);
  assign bus.in_ready  = !reset && (count < CNT_DEPTH);
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop           = bus.out_valid && bus.out_ready && !bus.flush;

  // Next pointer/count state and the entry that becomes head next cycle
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_nxt    = wr_ptr;
    rd_nxt    = rd_ptr;
    cnt_nxt   = count;
    load_head = 1'b0;
    head_nxt  = head;
    if (bus.flush) begin
      wr_nxt  = '0;
      rd_nxt  = '0;
      cnt_nxt = '0;
    end else begin
      if (push) wr_nxt = bump(wr_ptr);
      if (pop)  rd_nxt = bump(rd_ptr);
      if (push && !pop)      cnt_nxt = count + 1'b1;
      else if (pop && !push) cnt_nxt = count - 1'b1;
      // Head changes when the old head leaves or the buffer was empty
      if ((pop || count == '0) && cnt_nxt != '0) begin
        load_head = 1'b1;
        head_nxt  = (push && rd_nxt == wr_ptr) ? new_entry : mem[rd_nxt];
      end
    end
  end

  // Entry storage written on each accepted push
  // NOTE: the storage array is not reset; only count/pointers/head define visible state.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  // Pointers, occupancy and head register
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      if (load_head) head <= head_nxt;
    end
  end

  assign bus.out_opcode    = head.opcode;
  assign bus.out_rs        = head.rs;
  assign bus.out_rt        = head.rt;
  assign bus.out_rd        = head.rd;
  assign bus.out_imm       = head.rd;
  assign bus.out_jtarget   = head.jtarget;
  assign bus.out_pc        = head.pc;
  assign bus.out_pc_plus1  = head.pc_plus1;
  assign bus.out_reg_write = head.reg_write;
  assign bus.out_mem_read  = head.mem_read;
  assign bus.out_mem_write = head.mem_write;
  assign bus.out_jump      = head.jump;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The module SHALL have parameter DEPTH, default 2, meaning the number of buffered instruction entries (legal values 2 or 4).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, an asynchronous, active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1, indicating the fetch stage is offering an instruction.
REQ-005 The module SHALL have port in_ready, output, 1, indicating the stage accepts the offered instruction this cycle.
REQ-006 The module SHALL have port in_instr, input, 8, the fetched instruction.
REQ-007 The module SHALL have port in_pc, input, 8, the address of in_instr.
REQ-008 The module SHALL have port flush, input, 1, which discards all buffered entries.
REQ-009 The module SHALL have port out_valid, output, 1, indicating the head entry is valid.
REQ-010 The module SHALL have port out_ready, input, 1, indicating the downstream stage consumes the head entry.
REQ-011 The module SHALL have output fields out_opcode (2 bits), out_rs (2), out_rt (2), out_rd (2), out_imm (2, raw and unextended, feeding the 2-to-8 sign extender), out_jtarget (6), out_pc (8) and out_pc_plus1 (8).
REQ-012 The module SHALL have control outputs out_reg_write, out_mem_read, out_mem_write and out_jump, each 1 bit.

Function
REQ-013 The instruction fields SHALL decode as: opcode=[7:6], rs=[5:4], rt=[3:2], rd=imm=[1:0], jtarget=[5:0].
REQ-014 Opcodes SHALL decode as: 00 ADD (reg_write=1), 01 LWD (reg_write=1, mem_read=1), 10 SWD (mem_write=1), 11 JMP (jump=1); all other control bits SHALL be 0.
REQ-015 Decode SHALL be performed at push time, and the decoded fields SHALL be stored in the entry.
REQ-016 All out_* fields SHALL be driven directly from the head-entry registers, with no combinational path from in_* to out_*.
REQ-017 out_pc_plus1 SHALL equal stored pc+1, modulo 256 (8'hFF yields 8'h00).
REQ-018 A push SHALL occur when in_valid and in_ready are both 1.
REQ-019 A pop SHALL occur when out_valid and out_ready are both 1.
REQ-020 in_ready SHALL equal (count < DEPTH) and SHALL have no combinational dependence on out_ready.
REQ-021 out_valid SHALL equal (count != 0).
REQ-022 Latency SHALL be 1 cycle: an instruction pushed at edge N SHALL be visible with out_valid=1 after edge N.
REQ-023 Entries SHALL leave in push order; read and write pointers SHALL wrap modulo DEPTH.
REQ-024 A simultaneous push and pop SHALL leave count unchanged, and the head SHALL advance to the next entry, or to the newly pushed entry if count was 1.
REQ-025 When full, in_ready SHALL be 0, so that a pop at full only frees a slot for the next cycle.
REQ-026 When empty, out_ready SHALL be ignored, and out_* fields other than out_valid SHALL hold their last values.
REQ-027 flush SHALL set count and both pointers to 0 at the next edge, overriding any push or pop that cycle, and the flushed in_instr SHALL be dropped.
REQ-028 count SHALL be held in a register wide enough for 0..DEPTH and SHALL never exceed DEPTH or go below 0.

Reset
REQ-029 Asserting reset SHALL immediately set count, both pointers, out_valid and every out_* field and control bit to 0.
REQ-030 While reset is asserted, in_ready SHALL be 0.
REQ-031 In the first cycle after deassertion, in_ready SHALL be 1.
REQ-032 Reset asserted mid-operation SHALL discard all entries, with no pop observed.

Verification
REQ-033 Single instruction: push 8'h5B (LWD) with pc=8'h10 and out_ready=1 -> next cycle out_valid=1, opcode=01, rs=01, rt=10, imm=11, mem_read=1, reg_write=1, pc_plus1=8'h11; after the pop, out_valid=0.
REQ-034 Fill and backpressure: hold out_ready=0 and push 8'h01, 8'h82, 8'hC7 -> the first two are accepted, in_ready=0 on the third, and the output shows 8'h01 fields.
REQ-035 Full with simultaneous events: at full, raise out_ready=1 with in_valid=1 -> one pop, no push that cycle, and the third instruction is accepted the next cycle with order 01, 82, C7 preserved.
REQ-036 Flush priority: with count=1, assert flush, in_valid=1 and out_ready=1 in the same cycle -> count=0 next cycle and the offered instruction never appears.
REQ-037 PC wrap and JMP: push 8'hFF with pc=8'hFF -> jump=1, jtarget=6'h3F, pc_plus1=8'h00.
REQ-038 Asynchronous reset: assert reset between edges with count=2 -> out_valid=0 and all outputs 0 immediately, before the next edge.
